// File: rtl/bottling_pkg.sv
// Shared types and constants for the bottling line sequencer.
package bottling_pkg;

  // Sequencer states; the encodings are visible on the state output.
  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CONVEY  = 3'd1,
    S_FILL    = 3'd2,
    S_CAP     = 3'd3,
    S_RELEASE = 3'd4,
    S_DONE    = 3'd5,
    S_FAULT   = 3'd6
  } state_t;

  // Default number of FILL cycles allowed before the watchdog trips.
  localparam int FILL_TIMEOUT_DEF = 200;

endpackage

// File: rtl/bottle_counter.sv
// Eight-bit bottle count with synchronous clear (priority) and increment enable.
module bottle_counter (
  input  logic       clk,
  input  logic       i_clr,
  input  logic       i_en,
  output logic [7:0] o_count
);

  logic [7:0] r_count;

  // Clear wins over increment; the count wraps naturally at 8 bits.
  always_ff @(posedge clk) begin
    if (i_clr) begin
      r_count <= 8'd0;
    end else if (i_en) begin
      r_count <= r_count + 8'd1;
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/bottling_sequencer.sv
// Bottling line sequencer: convey, fill, cap and release bottles until a
// latched batch size is reached. Optional fill watchdog enabled by defining
// FILL_WATCHDOG_EN; without it FILL waits indefinitely and alarm is 0.
module bottling_sequencer
  import bottling_pkg::*;
#(
  parameter int FILL_TIMEOUT = FILL_TIMEOUT_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       stop,
  input  logic       bottle_sensor,
  input  logic       level_sensor,
  input  logic       cap_done,
  input  logic [7:0] batch_size,
  output logic       motor,
  output logic       valve,
  output logic       cap_cmd,
  output logic [7:0] count,
  output logic       batch_done,
  output logic       alarm,
  output logic [2:0] state
);

  state_t     r_state;
  state_t     w_next;
  logic [7:0] r_batch;
  logic [7:0] w_count;
  logic [7:0] w_count_inc;
  logic       w_cap_hit;
  logic       w_last;
  logic       w_timeout;
  logic       w_motor;
  logic       w_valve;
  logic       w_cap_cmd;
  logic       w_batch_done;

  // A bottle counts only when capping completes without a competing stop.
  assign w_cap_hit   = (r_state == S_CAP) && cap_done && !stop;
  assign w_count_inc = w_count + 8'd1;
  // Batch size 0 means 256: the wrapped increment then matches 0.
  assign w_last      = (w_count_inc == r_batch);

`ifdef FILL_WATCHDOG_EN
  localparam int TW = (FILL_TIMEOUT > 2) ? $clog2(FILL_TIMEOUT) : 1;
  logic [TW-1:0] r_timer;

  // Fill timer runs from 0 while in FILL and rests at 0 elsewhere.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_timer <= '0;
    end else if (r_state == S_FILL) begin
      r_timer <= r_timer + TW'(1);
    end else begin
      r_timer <= '0;
    end
  end

  assign w_timeout = (r_timer == TW'(FILL_TIMEOUT - 1));
  assign alarm     = (r_state == S_FAULT);
`else
  assign w_timeout = 1'b0;
  assign alarm     = 1'b0;
`endif

  // State register and batch-size latch (captured on a successful start).
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_batch <= 8'd0;
    end else begin
      r_state <= w_next;
      if ((r_state == S_IDLE) && start && !stop) begin
        r_batch <= batch_size;
      end
    end
  end

  // Next-state logic and actuator decode (outputs depend on state only).
  always_comb begin
    w_next       = r_state;
    w_motor      = 1'b0;
    w_valve      = 1'b0;
    w_cap_cmd    = 1'b0;
    w_batch_done = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start && !stop) w_next = S_CONVEY;
      end
      S_CONVEY: begin
        w_motor = 1'b1;
        if (stop)               w_next = S_IDLE;
        else if (bottle_sensor) w_next = S_FILL;
      end
      S_FILL: begin
        w_valve = 1'b1;
        if (stop)              w_next = S_IDLE;
        else if (level_sensor) w_next = S_CAP;
        else if (w_timeout)    w_next = S_FAULT;
      end
      S_CAP: begin
        w_cap_cmd = 1'b1;
        if (stop)          w_next = S_IDLE;
        else if (cap_done) w_next = w_last ? S_DONE : S_RELEASE;
      end
      S_RELEASE: begin
        w_motor = 1'b1;
        // Wait for the capped bottle to leave so it is not counted twice.
        if (stop)                w_next = S_IDLE;
        else if (!bottle_sensor) w_next = S_CONVEY;
      end
      S_DONE: begin
        w_batch_done = 1'b1;
        w_next       = S_IDLE;
      end
      S_FAULT: begin
        w_next = S_FAULT;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  bottle_counter u_counter (
    .clk     (clk),
    .i_clr   (reset || (r_state == S_DONE)),
    .i_en    (w_cap_hit),
    .o_count (w_count)
  );

  assign motor      = w_motor;
  assign valve      = w_valve;
  assign cap_cmd    = w_cap_cmd;
  assign batch_done = w_batch_done;
  assign count      = w_count;
  assign state      = r_state;

endmodule

// File: tb/tb_bottling_sequencer.sv
// Scoreboard bench for bottling_sequencer. Define FILL_WATCHDOG_EN to also
// cover the fill watchdog (DUT built with FILL_TIMEOUT=10).
module tb_bottling_sequencer;
  import bottling_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       stop;
  logic       bottle_sensor;
  logic       level_sensor;
  logic       cap_done;
  logic [7:0] batch_size;
  logic       motor;
  logic       valve;
  logic       cap_cmd;
  logic [7:0] count;
  logic       batch_done;
  logic       alarm;
  logic [2:0] state;

  int n_checks = 0;
  int n_fail   = 0;
  int m_count  = 0;
  int m_batch  = 0;
  int exp_q[$];

  bottling_sequencer #(.FILL_TIMEOUT(10)) dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .stop          (stop),
    .bottle_sensor (bottle_sensor),
    .level_sensor  (level_sensor),
    .cap_done      (cap_done),
    .batch_size    (batch_size),
    .motor         (motor),
    .valve         (valve),
    .cap_cmd       (cap_cmd),
    .count         (count),
    .batch_done    (batch_done),
    .alarm         (alarm),
    .state         (state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [7:0] bs);
    batch_size = bs;
    start      = 1'b1;
    tick();
    start      = 1'b0;
    m_batch    = bs;
    chk("start_state", 32'(state), 32'(S_CONVEY));
    chk("start_motor", 32'(motor), 1);
  endtask

  // One full bottle from CONVEY; hold keeps bottle_sensor high in RELEASE.
  task automatic bottle(input int hold);
    chk("conv_state", 32'(state), 32'(S_CONVEY));
    bottle_sensor = 1'b1;
    tick();
    chk("fill_state", 32'(state), 32'(S_FILL));
    chk("fill_valve", 32'(valve), 1);
    chk("fill_motor", 32'(motor), 0);
    tick();
    level_sensor = 1'b1;
    tick();
    level_sensor = 1'b0;
    chk("cap_state", 32'(state), 32'(S_CAP));
    chk("cap_cmd", 32'(cap_cmd), 1);
    cap_done = 1'b1;
    m_count  = (m_count + 1) % 256;
    exp_q.push_back(m_count);
    tick();
    cap_done = 1'b0;
    chk("count_inc", 32'(count), 32'(exp_q.pop_front()));
    if (m_count == m_batch) begin
      chk("done_state", 32'(state), 32'(S_DONE));
      chk("done_pulse", 32'(batch_done), 1);
      bottle_sensor = 1'b0;
      tick();
      chk("done_idle", 32'(state), 32'(S_IDLE));
      chk("done_pulse_end", 32'(batch_done), 0);
      chk("done_count_clr", 32'(count), 0);
      m_count = 0;
    end else begin
      chk("rel_state", 32'(state), 32'(S_RELEASE));
      chk("rel_motor", 32'(motor), 1);
      chk("rel_no_done", 32'(batch_done), 0);
      for (int i = 0; i < hold; i++) begin
        tick();
        chk("rel_hold_state", 32'(state), 32'(S_RELEASE));
        chk("rel_hold_count", 32'(count), 32'(m_count));
      end
      bottle_sensor = 1'b0;
      tick();
      chk("rel_to_conv", 32'(state), 32'(S_CONVEY));
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; stop = 1'b0; bottle_sensor = 1'b0;
    level_sensor = 1'b0; cap_done = 1'b0; batch_size = 8'd0;
    tick();
    tick();
    reset = 1'b0;
    chk("rst_state", 32'(state), 32'(S_IDLE));
    chk("rst_count", 32'(count), 0);
    chk("rst_motor", 32'(motor), 0);
    chk("rst_valve", 32'(valve), 0);
    chk("rst_cap", 32'(cap_cmd), 0);
    chk("rst_done", 32'(batch_done), 0);
    chk("rst_alarm", 32'(alarm), 0);

    // Batch of 3, first bottle lingers 5 cycles in RELEASE.
    do_start(8'd3);
    bottle(5);
    bottle(0);
    bottle(0);

    // Stop in FILL at count 2, then restart and finish the batch.
    do_start(8'd3);
    bottle(0);
    bottle(0);
    bottle_sensor = 1'b1;
    tick();
    chk("stopfill_pre", 32'(state), 32'(S_FILL));
    stop = 1'b1;
    tick();
    stop = 1'b0;
    bottle_sensor = 1'b0;
    chk("stopfill_state", 32'(state), 32'(S_IDLE));
    chk("stopfill_valve", 32'(valve), 0);
    chk("stopfill_count", 32'(count), 2);
    do_start(8'd3);
    bottle(0);

    // stop and cap_done in the same CAP cycle: no increment.
    do_start(8'd5);
    bottle(0);
    bottle_sensor = 1'b1;
    tick();
    level_sensor = 1'b1;
    tick();
    level_sensor = 1'b0;
    chk("coinc_cap", 32'(state), 32'(S_CAP));
    stop = 1'b1;
    cap_done = 1'b1;
    tick();
    stop = 1'b0;
    cap_done = 1'b0;
    bottle_sensor = 1'b0;
    chk("coinc_state", 32'(state), 32'(S_IDLE));
    chk("coinc_count", 32'(count), 1);
    chk("coinc_capcmd", 32'(cap_cmd), 0);

    // Reset mid-fill overrides start and stop.
    do_start(8'd5);
    bottle_sensor = 1'b1;
    tick();
    reset = 1'b1; start = 1'b1; stop = 1'b1;
    tick();
    reset = 1'b0; start = 1'b0; stop = 1'b0; bottle_sensor = 1'b0;
    m_count = 0;
    chk("rstfill_state", 32'(state), 32'(S_IDLE));
    chk("rstfill_count", 32'(count), 0);
    chk("rstfill_valve", 32'(valve), 0);

    // Fill without level_sensor.
    do_start(8'd4);
    bottle_sensor = 1'b1;
    tick();
    chk("wd_fill", 32'(state), 32'(S_FILL));
`ifdef FILL_WATCHDOG_EN
    for (int i = 0; i < 9; i++) begin
      tick();
      chk("wd_still_fill", 32'(state), 32'(S_FILL));
    end
    tick();
    chk("wd_fault", 32'(state), 32'(S_FAULT));
    chk("wd_alarm", 32'(alarm), 1);
    chk("wd_valve", 32'(valve), 0);
    chk("wd_motor", 32'(motor), 0);
    start = 1'b1;
    bottle_sensor = 1'b0;
    tick();
    start = 1'b0;
    chk("wd_sticky", 32'(state), 32'(S_FAULT));
    chk("wd_alarm_sticky", 32'(alarm), 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("wd_rst_state", 32'(state), 32'(S_IDLE));
    chk("wd_rst_alarm", 32'(alarm), 0);
`else
    for (int i = 0; i < 15; i++) begin
      tick();
      chk("nowd_fill", 32'(state), 32'(S_FILL));
      chk("nowd_alarm", 32'(alarm), 0);
    end
    stop = 1'b1;
    tick();
    stop = 1'b0;
    bottle_sensor = 1'b0;
    chk("nowd_stop", 32'(state), 32'(S_IDLE));
`endif
    reset = 1'b1;
    tick();
    reset = 1'b0;
    m_count = 0;

    // batch_size 0 means 256 bottles; count wraps to 0 on the last one.
    do_start(8'd0);
    for (int b = 0; b < 256; b++) begin
      bottle(0);
    end
    chk("b256_idle", 32'(state), 32'(S_IDLE));
    chk("b256_count", 32'(count), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
